// File: rtl/demux_1to16_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_1to16_capture_pkg                                              |
// | Shared constants and the FILL/FULL state type for the capture demux. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package demux_1to16_capture_pkg;

    localparam int c_WIDTH = 16;
    localparam int c_IDX_W = 4;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/demux_1to16_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_1to16_dec                                                      |
// | 4-to-16 one-hot write-enable decoder, gated by the accept strobe.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module demux_1to16_dec
    import demux_1to16_capture_pkg::*;
(
    input  logic [c_IDX_W-1:0] idx,
    input  logic               en,
    output logic [c_WIDTH-1:0] onehot
);

    for (genvar gi = 0; gi < c_WIDTH; gi++) begin : g_dec
        assign onehot[gi] = en && (idx == c_IDX_W'(gi));
    end

endmodule
`default_nettype wire

// File: rtl/demux_1to16_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | demux_1to16_capture                                                  |
// | Serial bit demux into a 16-bit frame, handed off with valid/ack.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module demux_1to16_capture
    import demux_1to16_capture_pkg::*;
#(
    parameter logic [c_WIDTH-1:0] RESET_VAL = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    input  logic               din_vld,
    output logic               din_rdy,
    input  logic [c_IDX_W-1:0] sel,
    input  logic               sel_mode,
    input  logic               clr,
    output logic [c_WIDTH-1:0] demux_out,
    output logic               frame_vld,
    input  logic               frame_ack
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_WIDTH-1:0]   r_demux_out;
    logic [c_WIDTH-1:0]   r_mask;
    logic [c_IDX_W-1:0]   r_ptr;

    logic                 w_accept;
    logic [c_IDX_W-1:0]   w_idx;
    logic [c_WIDTH-1:0]   w_we;
    logic [c_WIDTH-1:0]   w_mask_nxt;

    // clr kills any write in the same cycle, so it gates the decoder enable
    assign w_accept   = din_vld && (r_state == ST_FILL) && !clr;
    assign w_idx      = sel_mode ? r_ptr : sel;
    assign w_mask_nxt = r_mask | w_we;

    demux_1to16_dec u_dec (
        .idx    (w_idx),
        .en     (w_accept),
        .onehot (w_we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_FILL;
        end else begin
            case (r_state)
                ST_FILL: if (w_accept && (&w_mask_nxt)) w_state_nxt = ST_FULL;
                ST_FULL: if (frame_ack)                 w_state_nxt = ST_FILL;
                default:                                w_state_nxt = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_demux_out <= RESET_VAL;
            r_mask      <= '0;
            r_ptr       <= '0;
        end else if (clr) begin
            r_demux_out <= RESET_VAL;
            r_mask      <= '0;
            r_ptr       <= '0;
        end else if (r_state == ST_FULL) begin
            // captured word stays put across the ack; only bookkeeping resets
            if (frame_ack) begin
                r_mask <= '0;
                r_ptr  <= '0;
            end
        end else if (w_accept) begin
            r_demux_out <= (r_demux_out & ~w_we) | ({c_WIDTH{din}} & w_we);
            r_mask      <= w_mask_nxt;
            if (sel_mode) r_ptr <= r_ptr + 1'b1;
        end
    end

    assign demux_out = r_demux_out;
    assign din_rdy   = (r_state == ST_FILL);
    assign frame_vld = (r_state == ST_FULL);

endmodule
`default_nettype wire

// File: tb/tb_demux_1to16_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_demux_1to16_capture                                               |
// | Directed scoreboard bench: expected frames are queued, a monitor     |
// | compares them on each frame_vld rising edge.  Rev 1.0                |
// +----------------------------------------------------------------------+
module tb_demux_1to16_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic        din_vld;
    logic        din_rdy;
    logic [3:0]  sel;
    logic        sel_mode;
    logic        clr;
    logic [15:0] demux_out;
    logic        frame_vld;
    logic        frame_ack;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    demux_1to16_capture #(.RESET_VAL(16'h0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_vld   (din_vld),
        .din_rdy   (din_rdy),
        .sel       (sel),
        .sel_mode  (sel_mode),
        .clr       (clr),
        .demux_out (demux_out),
        .frame_vld (frame_vld),
        .frame_ack (frame_ack)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one accepted-write attempt; returns #1 after the capturing edge
    task automatic wr(input logic mode, input logic [3:0] s, input logic d, input logic c);
        din_vld = 1'b1; sel_mode = mode; sel = s; din = d; clr = c;
        @(posedge clk); #1;
        din_vld = 1'b0; clr = 1'b0;
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; din = 1'b0; din_vld = 1'b0; sel = 4'h0;
        sel_mode = 1'b0; clr = 1'b0; frame_ack = 1'b0;

        fork
            begin : monitor
                logic prev_vld;
                prev_vld = 1'b0;
                forever begin
                    @(negedge clk);
                    if (frame_vld && !prev_vld) begin
                        if (exp_q.size() == 0) begin
                            check("frame_unexpected", demux_out, 16'hxxxx);
                        end else begin
                            check("frame_word", demux_out, exp_q.pop_front());
                        end
                    end
                    prev_vld = frame_vld;
                end
            end
        join_none

        #1;
        check("rst_din_rdy",   {15'd0, din_rdy},   16'd1);
        check("rst_frame_vld", {15'd0, frame_vld}, 16'd0);
        check("rst_demux_out", demux_out,          16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // auto fill, alternating 1,0 LSB first
        exp_q.push_back(16'h5555);
        for (int i = 0; i < 16; i++) wr(1'b1, 4'hF, (i % 2 == 0), 1'b0);
        check("auto_frame_vld", {15'd0, frame_vld}, 16'd1);
        check("auto_din_rdy",   {15'd0, din_rdy},   16'd0);

        // FULL ignores writes; ack with a simultaneous write is ack only
        din_vld = 1'b1; din = 1'b0; sel_mode = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("full_hold_out", demux_out, 16'h5555);
        ack();
        din_vld = 1'b0;
        check("ack_din_rdy",   {15'd0, din_rdy},   16'd1);
        check("ack_out_kept",  demux_out,          16'h5555);
        ack();
        check("ack_in_fill_ignored", {15'd0, din_rdy}, 16'd1);

        // addressed fill, descending, index 3 rewritten with 0
        exp_q.push_back(16'hFFF7);
        for (int s = 15; s >= 4; s--) wr(1'b0, 4'(s), 1'b1, 1'b0);
        wr(1'b0, 4'd3, 1'b1, 1'b0);
        wr(1'b0, 4'd3, 1'b0, 1'b0);
        wr(1'b0, 4'd2, 1'b1, 1'b0);
        wr(1'b0, 4'd1, 1'b1, 1'b0);
        check("addr_not_early", {15'd0, frame_vld}, 16'd0);
        wr(1'b0, 4'd0, 1'b1, 1'b0);
        check("addr_frame_vld", {15'd0, frame_vld}, 16'd1);
        @(negedge clk);
        ack();

        // clr on the write to index 7 discards everything
        for (int i = 0; i < 7; i++) wr(1'b1, 4'h0, 1'b1, 1'b0);
        wr(1'b1, 4'h0, 1'b1, 1'b1);
        check("clr_out",     demux_out,          16'h0000);
        check("clr_din_rdy", {15'd0, din_rdy},   16'd1);
        exp_q.push_back(16'h00FF);
        for (int i = 0; i < 15; i++) wr(1'b1, 4'h0, (i < 8), 1'b0);
        check("clr_not_early", {15'd0, frame_vld}, 16'd0);
        wr(1'b1, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        ack();

        // asynchronous reset mid-frame
        for (int i = 0; i < 9; i++) wr(1'b1, 4'h0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out",       demux_out,          16'h0000);
        check("arst_frame_vld", {15'd0, frame_vld}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.push_back(16'hF000);
        for (int i = 0; i < 15; i++) wr(1'b1, 4'h0, (i >= 12), 1'b0);
        check("arst_not_early", {15'd0, frame_vld}, 16'd0);
        wr(1'b1, 4'h0, 1'b1, 1'b0);
        @(negedge clk);
        ack();

        // mixed modes, then the next auto frame must start at ptr 0
        exp_q.push_back(16'h00FF);
        for (int i = 0; i < 8; i++) wr(1'b1, 4'hF, 1'b1, 1'b0);
        for (int s = 8; s < 16; s++) wr(1'b0, 4'(s), 1'b0, 1'b0);
        check("mixed_frame_vld", {15'd0, frame_vld}, 16'd1);
        @(negedge clk);
        ack();
        exp_q.push_back(16'h0001);
        for (int i = 0; i < 16; i++) wr(1'b1, 4'h0, (i == 0), 1'b0);
        repeat (2) @(negedge clk);

        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux_1to16_capture.md
DEMUX_1TO16_CAPTURE -- requirements
Module: demux_1to16_capture

Interface
REQ-001 Parameter RESET_VAL, default 16'h0000: the value loaded into demux_out at reset and on clr.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 din  input  1  serial data bit to be demultiplexed.
REQ-005 din_vld  input  1  din is valid this cycle.
REQ-006 din_rdy  output  1  block accepts din this cycle; a write occurs only when din_vld && din_rdy.
REQ-007 sel  input  4  target bit index for a write in addressed mode.
REQ-008 sel_mode  input  1  0 = addressed by sel; 1 = auto-increment by the internal pointer.
REQ-009 clr  input  1  synchronous clear of the frame.
REQ-010 demux_out  output  16  registered capture word; bit i holds the last din written to index i.
REQ-011 frame_vld  output  1  all 16 bits were written since the last ack or clear; demux_out is stable.
REQ-012 frame_ack  input  1  consumer has taken demux_out.

Function
REQ-013 The block SHALL have two states: FILL (din_rdy=1, frame_vld=0) and FULL (din_rdy=0, frame_vld=1).
REQ-014 On an accepted write, the target index SHALL be sel when sel_mode=0, or ptr[3:0] when sel_mode=1, with sel_mode sampled in the same cycle as the write.
REQ-015 On an accepted write, demux_out[index] SHALL take din, with the new value visible the cycle after the write (latency 1).
REQ-016 A 16-bit written_mask SHALL set bit[index] on each accepted write; rewriting an index overwrites the data and leaves the mask unchanged.
REQ-017 ptr SHALL increment mod 16 only on accepted auto-mode writes; it wraps 15->0; addressed writes do not move it.
REQ-018 When an accepted write makes written_mask all ones, the state SHALL go FILL->FULL, so frame_vld asserts on the next cycle.
REQ-019 In FULL, demux_out, ptr and written_mask SHALL hold, and din_vld SHALL be ignored.
REQ-020 In FULL, frame_ack SHALL cause FULL->FILL, written_mask<=0 and ptr<=0, with demux_out unchanged; din_rdy rises the cycle after the ack.
REQ-021 frame_ack in FILL SHALL be ignored.
REQ-022 A din_vld and frame_ack in the same FULL cycle SHALL be handled as an ack only; din is not captured.
REQ-023 clr SHALL have highest priority in both states: demux_out<=RESET_VAL, written_mask<=0, ptr<=0, state<=FILL; a simultaneous din_vld write is discarded.
REQ-024 Mixing modes within a frame SHALL be legal; completion depends only on written_mask.
REQ-025 All outputs SHALL be registered or decoded directly from the state register; there are no combinational paths from input to output.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force state=FILL, demux_out=RESET_VAL, written_mask=0 and ptr=0, so din_rdy=1 and frame_vld=0.
REQ-027 Reset deassertion SHALL be clean on the next clk edge; a reset mid-frame discards the partial frame and mask.

Structure
REQ-028 A shared package SHALL hold the state enum {FILL, FULL}, the WIDTH=16 constant and the index width of 4.
REQ-029 The block SHALL contain one sub-module, demux_1to16_dec, a 4-to-16 one-hot write-enable decoder qualified by the accept signal; it is the inverse of the team's 16:1 mux.

Verification
REQ-030 After reset with sel_mode=1, 16 accepted writes with din pattern 1010...(LSB first) SHALL give demux_out=16'h5555 and frame_vld=1 one cycle after the 16th write, with din_rdy=0.
REQ-031 With sel_mode=0, writes to sel=15..0 in descending order with din=1, where sel=3 is written twice (first 1, then 0), SHALL give demux_out=16'hFFF7 and frame_vld only after all 16 distinct indexes are written.
REQ-032 In FULL, holding din_vld=1 for 5 cycles and then pulsing frame_ack SHALL leave demux_out unchanged; din_rdy=1 the following cycle, with ptr=0 and mask=0.
REQ-033 An auto-mode write at index 7 together with clr=1 SHALL give demux_out=RESET_VAL, ptr=0 and no capture; the next 16 writes then complete a frame.
REQ-034 Asserting rst_n=0 asynchronously after 9 auto writes SHALL immediately give demux_out=RESET_VAL and frame_vld=0; afterwards, 16 further writes are needed to complete a frame.
REQ-035 An 8-write auto frame (ptr 0..7), then sel_mode=0 writes to sel=8..15, SHALL complete the frame; the subsequent auto frame starts at ptr=0.
